// File: rtl/board_tile_arbiter.sv
// Board tile arbiter: shares one board memory port between NUM_CH sprite read channels and a pellet write port.
// Latency: grant to response is RD_LAT+1 cycles on board, 1 cycle off board; a write acks 1 cycle after it is chosen.
// Backpressure: a requester holds req_valid until req_ready pulses; one transaction is in flight at a time.
// Ports: req_valid/req_x/req_y/req_ready form the read request side; rsp_valid/rsp_data carry the read result.
//        wr_req/wr_x/wr_y/wr_data/wr_ack form the write side; mem_* drive the board RAM; busy is high outside IDLE.
module board_tile_arbiter #(
   parameter int NUM_CH  = 5,
   parameter int COORD_W = 5,
   parameter int COLS    = 28,
   parameter int ROWS    = 31,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 4,
   parameter int RD_LAT  = 2,
   parameter logic [DATA_W-1:0] OOB_DATA = DATA_W'(1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          req_valid,
   input  logic [NUM_CH*COORD_W-1:0]  req_x,
   input  logic [NUM_CH*COORD_W-1:0]  req_y,
   output logic [NUM_CH-1:0]          req_ready,
   output logic [NUM_CH-1:0]          rsp_valid,
   output logic [DATA_W-1:0]          rsp_data,
   input  logic                       wr_req,
   input  logic [COORD_W-1:0]         wr_x,
   input  logic [COORD_W-1:0]         wr_y,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       wr_ack,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic                       mem_we,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic                       busy
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {IDLE, READ, RESP, WRITE} state_t;

   state_t              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [CH_W-1:0]     last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                wr_on_board_q, wr_on_board_d;
   logic                read_owed_q;

   logic                gnt_found;
   logic [CH_W-1:0]     gnt_idx;
   logic [COORD_W-1:0]  sel_x, sel_y;
   logic [NUM_CH-1:0]   req_ready_c, rsp_valid_c;
   logic                wr_ack_c, mem_we_c;

   function automatic logic [ADDR_W-1:0] tile_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
      return ADDR_W'(int'(y) * COLS + int'(x));
   endfunction

   function automatic logic on_board(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
      return (int'(x) < COLS) && (int'(y) < ROWS);
   endfunction

   // Round-robin: first requester strictly after the last grant, wrapping.
   always_comb begin : rr_search
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = int'(last_grant_q) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = CH_W'(idx);
         end
      end
   end

   assign sel_x = req_x[int'(gnt_idx)*COORD_W +: COORD_W];
   assign sel_y = req_y[int'(gnt_idx)*COORD_W +: COORD_W];

   always_comb begin
      state_d       = state_q;
      ch_d          = ch_q;
      last_grant_d  = last_grant_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      wr_on_board_d = wr_on_board_q;
      req_ready_c   = '0;
      rsp_valid_c   = '0;
      wr_ack_c      = 1'b0;
      mem_we_c      = 1'b0;
      case (state_q)
         IDLE: begin
            // Writes win, except in the IDLE cycle right after a write when a read is waiting.
            if (wr_req && (!(|req_valid) || !read_owed_q)) begin
               state_d       = WRITE;
               wdata_d       = wr_data;
               wr_on_board_d = on_board(wr_x, wr_y);
               if (on_board(wr_x, wr_y)) addr_d = tile_addr(wr_x, wr_y);
            end else if (gnt_found) begin
               req_ready_c[gnt_idx] = 1'b1;
               ch_d                 = gnt_idx;
               last_grant_d         = gnt_idx;
               cnt_d                = '0;
               if (on_board(sel_x, sel_y)) begin
                  addr_d  = tile_addr(sel_x, sel_y);
                  state_d = READ;
               end else begin
                  // Off-board reads see a wall without touching memory.
                  rdata_d = OOB_DATA;
                  state_d = RESP;
               end
            end
         end
         READ: begin
            if (cnt_q == CNT_W'(RD_LAT - 1)) begin
               rdata_d = mem_rdata;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            rsp_valid_c[ch_q] = 1'b1;
            state_d           = IDLE;
         end
         WRITE: begin
            mem_we_c = wr_on_board_q;
            wr_ack_c = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= IDLE;
         ch_q          <= '0;
         last_grant_q  <= CH_W'(NUM_CH - 1);
         cnt_q         <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         wr_on_board_q <= 1'b0;
         read_owed_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ch_q          <= ch_d;
         last_grant_q  <= last_grant_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         wr_on_board_q <= wr_on_board_d;
         // WRITE always returns to IDLE, so this marks exactly the IDLE cycle after a write.
         read_owed_q   <= (state_q == WRITE);
      end
   end

   // Outputs are forced low for as long as reset is held, even in IDLE with requests pending.
   assign req_ready = reset ? req_ready_c : '0;
   assign rsp_valid = reset ? rsp_valid_c : '0;
   assign rsp_data  = reset ? rdata_q     : '0;
   assign wr_ack    = reset && wr_ack_c;
   assign mem_we    = reset && mem_we_c;
   assign mem_addr  = reset ? addr_q      : '0;
   assign mem_wdata = reset ? wdata_q     : '0;
   assign busy      = reset && (state_q != IDLE);

endmodule

// File: tb/tb_board_tile_arbiter.sv
// Bench for board_tile_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Latency: checks sample at the falling edge; stimulus changes 1 time unit after the rising edge.
// Backpressure: requests are held until the model predicts their grant; writes until their predicted ack.
module tb_board_tile_arbiter;
   localparam int NUM_CH  = 5;
   localparam int COORD_W = 5;
   localparam int COLS    = 28;
   localparam int ROWS    = 31;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 4;
   localparam int RD_LAT  = 2;
   localparam logic [DATA_W-1:0] OOB = 4'h1;

   logic                      clock = 1'b0;
   logic                      reset;
   logic [NUM_CH-1:0]         req_valid;
   logic [NUM_CH*COORD_W-1:0] req_x, req_y;
   logic [NUM_CH-1:0]         req_ready, rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      wr_req, wr_ack;
   logic [COORD_W-1:0]        wr_x, wr_y;
   logic [DATA_W-1:0]         wr_data;
   logic [ADDR_W-1:0]         mem_addr;
   logic                      mem_we, busy;
   logic [DATA_W-1:0]         mem_wdata, mem_rdata;

   logic [DATA_W-1:0] mem    [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];

   int vectors = 0;
   int miscompares = 0;

   board_tile_arbiter dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clock = ~clock;

   // Board RAM: combinational read, write on the rising edge.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clock) if (mem_we) mem[mem_addr] = mem_wdata;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = '0; req_x = '0; req_y = '0;
      wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   task automatic set_req(input int ch, input int x, input int y);
      req_valid[ch] = 1'b1;
      req_x[ch*COORD_W +: COORD_W] = COORD_W'(x);
      req_y[ch*COORD_W +: COORD_W] = COORD_W'(y);
   endtask

   function automatic int rand_x();
      return ($urandom_range(0, 5) == 0) ? int'($urandom_range(COLS, 31)) : int'($urandom_range(0, COLS-1));
   endfunction

   function automatic int rand_y();
      return ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, ROWS-1));
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      req_valid = '1; wr_req = 1'b1; wr_x = 5'd1; wr_y = 5'd1; wr_data = 4'hF;
      repeat (2) @(posedge clock);
      @(negedge clock);
      vectors++; if (req_ready !== 5'b0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 00000", req_ready); end
      vectors++; if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_write: wr_ack=%b mem_we=%b want 0 0", wr_ack, mem_we); end
      vectors++; if (busy !== 1'b0 || rsp_valid !== 5'b0) begin miscompares++; $display("FAIL reset_busy_rsp: busy=%b rsp_valid=%b want 0 00000", busy, rsp_valid); end
      vectors++; if (mem_addr !== 10'd0 || rsp_data !== 4'h0 || mem_wdata !== 4'h0) begin miscompares++; $display("FAIL reset_data: addr=%0d rsp_data=%h wdata=%h want 0 0 0", mem_addr, rsp_data, mem_wdata); end
      tick();
      reset = 1'b1;
      clear_inputs();
      @(negedge clock);
      vectors++; if (busy !== 1'b0 || req_ready !== 5'b0) begin miscompares++; $display("FAIL reset_release_idle: busy=%b req_ready=%b want 0 00000", busy, req_ready); end
      tick();
   endtask

   task automatic test_single_read();
      do_reset();
      mem[59] = 4'h2;
      set_req(0, 3, 2);
      @(negedge clock);
      vectors++; if (req_ready !== 5'b00001) begin miscompares++; $display("FAIL single_grant: req_ready=%b want 00001", req_ready); end
      tick(); req_valid[0] = 1'b0;
      @(negedge clock);
      vectors++; if (mem_addr !== 10'd59 || mem_we !== 1'b0 || req_ready !== 5'b0) begin miscompares++; $display("FAIL single_read1: addr=%0d we=%b rdy=%b want 59 0 00000", mem_addr, mem_we, req_ready); end
      tick();
      @(negedge clock);
      vectors++; if (mem_addr !== 10'd59 || rsp_valid !== 5'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_read2: addr=%0d rsp_valid=%b busy=%b want 59 00000 1", mem_addr, rsp_valid, busy); end
      tick();
      @(negedge clock);
      vectors++; if (rsp_valid !== 5'b00001) begin miscompares++; $display("FAIL single_rsp_valid: got %b want 00001", rsp_valid); end
      vectors++; if (rsp_data !== 4'h2) begin miscompares++; $display("FAIL single_rsp_data: got %h want 2", rsp_data); end
      tick();
      @(negedge clock);
      vectors++; if (rsp_valid !== 5'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_done: rsp_valid=%b busy=%b want 00000 0", rsp_valid, busy); end
   endtask

   task automatic test_round_robin();
      logic [NUM_CH-1:0] exp_oh;
      logic [DATA_W-1:0] exp_d;
      int ch;
      do_reset();
      for (int i = 0; i < NUM_CH; i++) set_req(i, i + 1, i);
      for (int t = 0; t < 6; t++) begin
         ch = t % NUM_CH;
         exp_oh = NUM_CH'(1 << ch);
         exp_d = mem[ch*COLS + ch + 1];
         @(negedge clock);
         vectors++; if (req_ready !== exp_oh) begin miscompares++; $display("FAIL rr_grant%0d: req_ready=%b want %b", t, req_ready, exp_oh); end
         repeat (3) tick();
         @(negedge clock);
         vectors++; if (rsp_valid !== exp_oh || rsp_data !== exp_d) begin miscompares++; $display("FAIL rr_rsp%0d: rsp_valid=%b data=%h want %b %h", t, rsp_valid, rsp_data, exp_oh, exp_d); end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_write_priority();
      do_reset();
      wr_req = 1'b1; wr_x = 5'd5; wr_y = 5'd1; wr_data = 4'h7;
      set_req(2, 2, 3);
      @(negedge clock);
      vectors++; if (req_ready !== 5'b0) begin miscompares++; $display("FAIL wp_write_first: req_ready=%b want 00000", req_ready); end
      tick();
      @(negedge clock);
      vectors++; if (mem_we !== 1'b1 || wr_ack !== 1'b1 || mem_addr !== 10'd33 || mem_wdata !== 4'h7) begin miscompares++; $display("FAIL wp_write1: we=%b ack=%b addr=%0d wdata=%h want 1 1 33 7", mem_we, wr_ack, mem_addr, mem_wdata); end
      tick(); wr_data = 4'h9;
      @(negedge clock);
      vectors++; if (req_ready !== 5'b00100 || mem_we !== 1'b0) begin miscompares++; $display("FAIL wp_read_owed: req_ready=%b we=%b want 00100 0", req_ready, mem_we); end
      tick(); req_valid[2] = 1'b0;
      tick(); tick();
      @(negedge clock);
      vectors++; if (rsp_valid !== 5'b00100 || rsp_data !== mem[3*COLS+2]) begin miscompares++; $display("FAIL wp_read_rsp: rsp_valid=%b data=%h want 00100 %h", rsp_valid, rsp_data, mem[3*COLS+2]); end
      tick(); tick();
      @(negedge clock);
      vectors++; if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 4'h9) begin miscompares++; $display("FAIL wp_write2: ack=%b we=%b wdata=%h want 1 1 9", wr_ack, mem_we, mem_wdata); end
      tick(); wr_req = 1'b0;
      @(negedge clock);
      vectors++; if (mem[33] !== 4'h9 || wr_ack !== 1'b0) begin miscompares++; $display("FAIL wp_mem_content: mem[33]=%h ack=%b want 9 0", mem[33], wr_ack); end
   endtask

   task automatic test_off_board();
      do_reset();
      set_req(1, 30, 0);
      @(negedge clock);
      vectors++; if (req_ready !== 5'b00010) begin miscompares++; $display("FAIL oob_grant: req_ready=%b want 00010", req_ready); end
      tick(); req_valid[1] = 1'b0;
      @(negedge clock);
      vectors++; if (rsp_valid !== 5'b00010 || rsp_data !== OOB) begin miscompares++; $display("FAIL oob_rsp: rsp_valid=%b data=%h want 00010 %h", rsp_valid, rsp_data, OOB); end
      vectors++; if (mem_addr !== 10'd0) begin miscompares++; $display("FAIL oob_addr_kept: addr=%0d want 0", mem_addr); end
      tick(); wr_req = 1'b1; wr_x = 5'd31; wr_y = 5'd0; wr_data = 4'h5;
      tick();
      @(negedge clock);
      vectors++; if (wr_ack !== 1'b1 || mem_we !== 1'b0) begin miscompares++; $display("FAIL oob_write: ack=%b we=%b want 1 0", wr_ack, mem_we); end
      tick(); wr_req = 1'b0;
      @(negedge clock);
      vectors++; if (wr_ack !== 1'b0) begin miscompares++; $display("FAIL oob_write_done: ack=%b want 0", wr_ack); end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      set_req(3, 1, 1);
      @(negedge clock);
      vectors++; if (req_ready !== 5'b01000) begin miscompares++; $display("FAIL mid_grant: req_ready=%b want 01000", req_ready); end
      tick(); req_valid = '0; reset = 1'b0;
      @(negedge clock);
      vectors++; if (busy !== 1'b0 || mem_addr !== 10'd0) begin miscompares++; $display("FAIL mid_reset_outputs: busy=%b addr=%0d want 0 0", busy, mem_addr); end
      tick();
      @(negedge clock);
      vectors++; if (busy !== 1'b0 || rsp_valid !== 5'b0 || rsp_data !== 4'h0) begin miscompares++; $display("FAIL mid_reset_edge: busy=%b rsp_valid=%b data=%h want 0 00000 0", busy, rsp_valid, rsp_data); end
      tick(); reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         vectors++; if (rsp_valid !== 5'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_stale%0d: rsp_valid=%b busy=%b want 00000 0", i, rsp_valid, busy); end
         tick();
      end
      set_req(0, 2, 2); set_req(3, 1, 1);
      @(negedge clock);
      vectors++; if (req_ready !== 5'b00001) begin miscompares++; $display("FAIL mid_next_grant: req_ready=%b want 00001", req_ready); end
      tick(); clear_inputs();
   endtask

   task automatic test_random(input int ncyc);
      int idle_at, rsp_at, ack_at, owe_at, rsp_ch, last, g, gx, gy, idx, gnt_prev;
      bit ack_prev, idle_now, any_req, we_pend, e_ack, e_we;
      logic [DATA_W-1:0] rsp_dat, wd_exp;
      logic [ADDR_W-1:0] wa_exp;
      logic [NUM_CH-1:0] e_rdy, e_rsp;
      do_reset();
      for (int a = 0; a < (1 << ADDR_W); a++) shadow[a] = mem[a];
      last = NUM_CH - 1; idle_at = 0; rsp_at = -1; ack_at = -1; owe_at = -1; gnt_prev = -1;
      ack_prev = 0; rsp_ch = 0; rsp_dat = '0; wd_exp = '0; wa_exp = '0; we_pend = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (gnt_prev >= 0) req_valid[gnt_prev] = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (!req_valid[i] && $urandom_range(0, 3) == 0) set_req(i, rand_x(), rand_y());
            else if (req_valid[i] && $urandom_range(0, 40) == 0) req_valid[i] = 1'b0;
         end
         if (ack_prev || (!wr_req && $urandom_range(0, 5) == 0)) begin
            wr_req  = ack_prev ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_x    = COORD_W'(rand_x());
            wr_y    = COORD_W'(rand_y());
            wr_data = DATA_W'($urandom);
         end
         @(negedge clock);
         e_rdy = '0; e_rsp = '0; e_ack = 0; e_we = 0;
         if (c == rsp_at) e_rsp[rsp_ch] = 1'b1;
         if (c == ack_at) begin e_ack = 1; e_we = we_pend; end
         ack_prev = (c == ack_at);
         gnt_prev = -1;
         idle_now = (c >= idle_at);
         any_req  = |req_valid;
         if (idle_now) begin
            if (wr_req && (!any_req || c != owe_at)) begin
               ack_at = c + 1; idle_at = c + 2; owe_at = c + 2;
               we_pend = (int'(wr_x) < COLS) && (int'(wr_y) < ROWS);
               wa_exp  = ADDR_W'(int'(wr_y) * COLS + int'(wr_x));
               wd_exp  = wr_data;
               if (we_pend) shadow[wa_exp] = wr_data;
            end else if (any_req) begin
               g = -1;
               for (int k = 1; k <= NUM_CH; k++) begin
                  idx = (last + k) % NUM_CH;
                  if (g < 0 && req_valid[idx]) g = idx;
               end
               e_rdy[g] = 1'b1; last = g; gnt_prev = g; rsp_ch = g;
               gx = int'(req_x[g*COORD_W +: COORD_W]);
               gy = int'(req_y[g*COORD_W +: COORD_W]);
               if (gx >= COLS || gy >= ROWS) begin
                  rsp_at = c + 1; idle_at = c + 2; rsp_dat = OOB;
               end else begin
                  rsp_at = c + RD_LAT + 1; idle_at = c + RD_LAT + 2; rsp_dat = shadow[gy*COLS + gx];
               end
            end
         end
         vectors++; if (req_ready !== e_rdy) begin miscompares++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, req_ready, e_rdy); end
         vectors++; if (rsp_valid !== e_rsp) begin miscompares++; $display("FAIL rnd_rsp_valid c=%0d: got %b want %b", c, rsp_valid, e_rsp); end
         if (e_rsp != '0) begin
            vectors++; if (rsp_data !== rsp_dat) begin miscompares++; $display("FAIL rnd_rsp_data c=%0d: got %h want %h", c, rsp_data, rsp_dat); end
         end
         vectors++; if (wr_ack !== e_ack || mem_we !== e_we) begin miscompares++; $display("FAIL rnd_write c=%0d: ack=%b we=%b want %b %b", c, wr_ack, mem_we, e_ack, e_we); end
         if (e_we) begin
            vectors++; if (mem_addr !== wa_exp || mem_wdata !== wd_exp) begin miscompares++; $display("FAIL rnd_wr_bus c=%0d: addr=%0d wdata=%h want %0d %h", c, mem_addr, mem_wdata, wa_exp, wd_exp); end
         end
         vectors++; if (busy !== !idle_now) begin miscompares++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, !idle_now); end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      reset = 1'b0;
      clear_inputs();
      for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = DATA_W'($urandom);
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_priority();
      test_off_board();
      test_reset_mid_read();
      test_random(4000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/board_tile_arbiter.md
BOARD_TILE_ARBITER -- requirements
Module: board_tile_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): NUM_CH, 5, number of sprite read channels (Pac-Man plus ghosts).
REQ-002 SHALL have parameter COORD_W, 5, width of one tile coordinate.
REQ-003 SHALL have parameter COLS, 28, board columns; ROWS, 31, board rows.
REQ-004 SHALL have parameter ADDR_W, 10, board memory address width; DATA_W, 4, tile code width.
REQ-005 SHALL have parameter RD_LAT, 2, board memory read latency in cycles (1..4); OOB_DATA, 4'h1, tile code returned for off-board coordinates (wall).
REQ-006 SHALL have ports (name, direction, width, meaning): clock, in, 1, single system clock; all logic on its rising edge.
REQ-007 SHALL have reset, in, 1, synchronous, active-low reset.
REQ-008 SHALL have req_valid, in, NUM_CH, per-channel read request, held until granted.
REQ-009 SHALL have req_x and req_y, in, NUM_CH*COORD_W each, packed tile coordinates, channel i at bits [i*COORD_W +: COORD_W].
REQ-010 SHALL have req_ready, out, NUM_CH, one-hot grant pulse.
REQ-011 SHALL have rsp_valid, out, NUM_CH, one-hot response pulse; rsp_data, out, DATA_W, tile code qualified by rsp_valid.
REQ-012 SHALL have wr_req, in, 1, pellet-eaten write request; wr_x, wr_y, in, COORD_W; wr_data, in, DATA_W; wr_ack, out, 1, write-done pulse.
REQ-013 SHALL have mem_addr, out, ADDR_W; mem_we, out, 1; mem_wdata, out, DATA_W; mem_rdata, in, DATA_W; busy, out, 1, high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, READ, RESP, WRITE; one transaction in flight at a time.
REQ-015 SHALL compute address = y*COLS + x, truncated to ADDR_W.
REQ-016 In IDLE with wr_req high and (no req_valid or last_was_read=0 or no write since a read), SHALL go to WRITE; write has priority except as in REQ-017.
REQ-017 After any WRITE, if any req_valid is high in the next IDLE cycle, SHALL grant a read before another write (no read starvation).
REQ-018 Read grant SHALL be round-robin: search from (last_grant+1) mod NUM_CH upward with wrap; last_grant updates on each grant.
REQ-019 On grant SHALL pulse req_ready[i] for exactly one cycle (the IDLE cycle), latch channel, x, y, and enter READ.
REQ-020 READ SHALL drive mem_addr constant for RD_LAT cycles, mem_we=0, then capture mem_rdata into rsp_data and enter RESP.
REQ-021 RESP SHALL hold rsp_valid[ch]=1 for exactly one cycle, then return to IDLE; grant-to-response latency = RD_LAT+1 cycles.
REQ-022 If latched x>=COLS or y>=ROWS, SHALL skip READ, set rsp_data=OOB_DATA and enter RESP next cycle (latency 1); mem_addr not changed.
REQ-023 WRITE SHALL assert mem_we=1 with mem_addr and mem_wdata=wr_data for exactly one cycle and pulse wr_ack in that cycle; off-board write SHALL suppress mem_we but still pulse wr_ack.
REQ-024 mem_we SHALL be 0 in every state except WRITE; rsp_valid and req_ready SHALL never have more than one bit set.
REQ-025 A channel dropping req_valid before grant SHALL simply not be granted; no error state.

Reset
REQ-026 reset=0 at a clock edge SHALL force IDLE, last_grant=NUM_CH-1 (channel 0 first), last_was_read=0, all outputs 0, rsp_data=0.
REQ-027 Reset mid-READ or mid-RESP SHALL discard the in-flight response; no rsp_valid pulse after reset release.
REQ-028 Outputs SHALL stay 0 while reset=0 regardless of requests.

Verification
REQ-029 Single read: ch0 req (x=3,y=2), mem returns 4'h2 -> req_ready=00001 one cycle, mem_addr=59, rsp_valid=00001 with rsp_data=4'h2 exactly 3 cycles after grant.
REQ-030 All five channels requesting continuously -> grants in order 0,1,2,3,4,0, each channel's responses match its own addresses.
REQ-031 wr_req and ch2 req together -> WRITE first (mem_we 1 cycle, wr_ack), then ch2 read granted even with wr_req still high, then write again.
REQ-032 ch1 req (x=30,y=0) -> no memory read, rsp_valid=00010 with rsp_data=4'h1 one cycle after grant; wr at (x=31) -> wr_ack, mem_we stays 0.
REQ-033 reset=0 asserted one cycle into READ -> all outputs 0 next edge; after release no stale rsp_valid; next grant goes to channel 0.
